// File: rtl/img_ddr_loader.sv
// img_ddr_loader: packs the HPS ioctl byte stream of one file index into
// 64-bit words, writes them to a DDRAM channel through a req/ready handshake,
// throttles the HPS with ioctl_wait and captures the image header on the fly.
module img_ddr_loader #(
   parameter logic [7:0]  INDEX     = 8'd1,
   parameter logic [27:0] BASE_ADDR = 28'h0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [27:0] ch_addr,
   output logic [63:0] ch_din,
   output logic [7:0]  ch_be,
   output logic        ch_req,
   input  logic        ch_ready,
   output logic [15:0] hdr_width,
   output logic [15:0] hdr_height,
   output logic [31:0] hdr_frames,
   output logic        hdr_valid,
   output logic        img_loaded
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   state_t      r_state, w_next;
   logic        r_active_d, r_fell, r_wait, r_loaded;
   logic [63:0] r_word;
   logic [7:0]  r_be;
   logic [23:0] r_addr;
   logic        r_hold_valid;
   logic [7:0]  r_hold_byte;
   logic [2:0]  r_hold_lane;
   logic [23:0] r_hold_waddr;
   logic [15:0] r_hdr_width, r_hdr_height;
   logic [31:0] r_hdr_frames;
   logic        r_hdr_valid;

   logic        w_active, w_start, w_fall, w_wr;
   logic [2:0]  w_lane;
   logic [23:0] w_waddr;
   logic        w_merge, w_hold, w_clear, w_open, w_wait_nxt;

   assign w_active = ioctl_download && (ioctl_index == INDEX);
   assign w_start  = w_active && !r_active_d;
   assign w_fall   = !w_active && r_active_d;
   // a strobe coinciding with the download falling still belongs to it
   assign w_wr     = ioctl_wr && (ioctl_index == INDEX) && (ioctl_download || r_active_d);
   assign w_lane   = ioctl_addr[2:0];
   assign w_waddr  = ioctl_addr[26:3];

   assign ch_req     = (r_state == S_WRITE);
   assign ioctl_wait = r_wait;
   assign ch_addr    = BASE_ADDR + {1'b0, r_addr, 3'b000};
   assign ch_din     = r_word;
   assign ch_be      = r_be;
   assign hdr_width  = r_hdr_width;
   assign hdr_height = r_hdr_height;
   assign hdr_frames = r_hdr_frames;
   assign hdr_valid  = r_hdr_valid;
   assign img_loaded = r_loaded;

   // state register
   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state and datapath control
   always_comb begin
      w_next     = r_state;
      w_merge    = 1'b0;
      w_hold     = 1'b0;
      w_clear    = 1'b0;
      w_open     = 1'b0;
      w_wait_nxt = r_wait;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (w_wr) begin
               if (r_state == S_IDLE || r_be == 8'h00 || w_waddr == r_addr) begin
                  w_merge = 1'b1;
                  w_next  = S_COLLECT;
                  if (w_lane == 3'd7 || w_fall) begin
                     w_next     = S_WRITE;
                     w_wait_nxt = 1'b1;
                  end
               end else begin
                  w_hold     = 1'b1;
                  w_next     = S_WRITE;
                  w_wait_nxt = 1'b1;
               end
            end else if (r_state == S_COLLECT) begin
               // lane 7 present here only when a hold byte opened the word
               if (r_be[7]) begin
                  w_next     = S_WRITE;
                  w_wait_nxt = 1'b1;
               end else if (w_fall || r_fell) begin
                  w_next = (r_be != 8'h00) ? S_WRITE : S_DONE;
               end
            end
         end
         S_WRITE: begin
            if (ch_ready) begin
               w_clear    = 1'b1;
               w_wait_nxt = 1'b0;
               if (r_hold_valid) begin
                  w_open = 1'b1;
                  w_next = S_COLLECT;
               end else if (r_fell || w_fall) begin
                  w_next = S_DONE;
               end else begin
                  w_next = S_COLLECT;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // word assembly, hold byte, throttle, header capture and load flag
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_active_d   <= 1'b0;
         r_fell       <= 1'b0;
         r_wait       <= 1'b0;
         r_loaded     <= 1'b0;
         r_word       <= '0;
         r_be         <= '0;
         r_addr       <= '0;
         r_hold_valid <= 1'b0;
         r_hold_byte  <= '0;
         r_hold_lane  <= '0;
         r_hold_waddr <= '0;
         r_hdr_width  <= '0;
         r_hdr_height <= '0;
         r_hdr_frames <= '0;
         r_hdr_valid  <= 1'b0;
      end else begin
         r_active_d <= w_active;
         r_wait     <= w_wait_nxt;
         if (w_start)               r_fell <= 1'b0;
         else if (w_fall)           r_fell <= 1'b1;
         else if (r_state == S_DONE) r_fell <= 1'b0;

         if (w_clear) begin
            r_word <= '0;
            r_be   <= '0;
         end
         if (w_open) begin
            r_word       <= 64'(r_hold_byte) << {r_hold_lane, 3'b000};
            r_be         <= 8'b1 << r_hold_lane;
            r_addr       <= r_hold_waddr;
            r_hold_valid <= 1'b0;
         end
         if (w_merge) begin
            r_word[{w_lane, 3'b000} +: 8] <= ioctl_dout;
            r_be[w_lane]                  <= 1'b1;
            r_addr                        <= w_waddr;
         end
         if (w_hold) begin
            r_hold_valid <= 1'b1;
            r_hold_byte  <= ioctl_dout;
            r_hold_lane  <= w_lane;
            r_hold_waddr <= w_waddr;
         end

         if (w_start)                 r_loaded <= 1'b0;
         else if (r_state == S_DONE)  r_loaded <= 1'b1;

         if (w_start) begin
            r_hdr_width  <= '0;
            r_hdr_height <= '0;
            r_hdr_frames <= '0;
            r_hdr_valid  <= 1'b0;
         end
         if (w_wr && w_waddr == 24'd1) begin
            case (w_lane)
               3'd0: r_hdr_width[7:0]    <= ioctl_dout;
               3'd1: r_hdr_width[15:8]   <= ioctl_dout;
               3'd2: r_hdr_height[7:0]   <= ioctl_dout;
               3'd3: r_hdr_height[15:8]  <= ioctl_dout;
               3'd4: r_hdr_frames[7:0]   <= ioctl_dout;
               3'd5: r_hdr_frames[15:8]  <= ioctl_dout;
               3'd6: r_hdr_frames[23:16] <= ioctl_dout;
               default: begin
                  r_hdr_frames[31:24] <= ioctl_dout;
                  r_hdr_valid         <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
